// File: rtl/result_serializer_if.sv
// Result-word ingress and serial-beat egress bundle of the result serializer.
// slave is the serializer side, master is the producer/consumer side.
interface result_serializer_if #(
   parameter int DATA_WIDTH = 64,
   parameter int OUT_WIDTH  = 8,
   parameter int DEPTH      = 4
);
   logic                         valid_i;
   logic [DATA_WIDTH-1:0]        data_i;
   logic                         clear_i;
   logic                         out_ready_i;
   logic                         out_valid_o;
   logic [OUT_WIDTH-1:0]         out_data_o;
   logic                         out_last_o;
   logic                         overflow_o;
   logic                         empty_o;
   logic [$clog2(DEPTH+1)-1:0]   count_o;

   modport slave (
      input  valid_i, data_i, clear_i, out_ready_i,
      output out_valid_o, out_data_o, out_last_o, overflow_o, empty_o, count_o
   );

   modport master (
      output valid_i, data_i, clear_i, out_ready_i,
      input  out_valid_o, out_data_o, out_last_o, overflow_o, empty_o, count_o
   );
endinterface

// File: rtl/result_serializer.sv
// Queues DATA_WIDTH result words and emits them MSB-first as OUT_WIDTH beats; first beat 2 cycles after valid_i when idle.
// out_ready_i=0 holds the current beat; a word arriving at a full FIFO with no same-cycle pop is dropped and flags overflow.
module result_serializer #(
   parameter int DATA_WIDTH = 64,
   parameter int OUT_WIDTH  = 8,
   parameter int DEPTH      = 4
) (
   input  logic               clk_i,
   input  logic               rst_async_i,
   result_serializer_if.slave bus
);
   localparam int BEATS = DATA_WIDTH / OUT_WIDTH;
   localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW    = $clog2(DEPTH + 1);
   localparam logic [BW-1:0] PRE_LAST = BW'(BEATS - 2);
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t                state;
   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]         wr_ptr;
   logic [AW-1:0]         rd_ptr;
   logic [CW-1:0]         count;
   logic [DATA_WIDTH-1:0] shreg;
   logic [BW-1:0]         beat;
   logic                  out_valid;
   logic                  out_last;
   logic                  overflow;
   logic                  hs;
   logic                  pop;
   logic                  push;
   logic                  drop;

   // A full FIFO still accepts a word when the last beat hands over the head in the same cycle.
   assign hs   = out_valid && bus.out_ready_i;
   assign pop  = !bus.clear_i && (count != '0) && ((state == IDLE) || (hs && out_last));
   assign push = !bus.clear_i && bus.valid_i && ((count != FULL_CNT) || pop);
   assign drop = !bus.clear_i && bus.valid_i && (count == FULL_CNT) && !pop;

   always_ff @(posedge clk_i) begin
      if (push) begin
         mem[wr_ptr] <= bus.data_i;
      end
   end

   always_ff @(posedge clk_i or posedge rst_async_i) begin
      if (rst_async_i) begin
         state     <= IDLE;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         shreg     <= '0;
         beat      <= '0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         overflow  <= 1'b0;
      end else if (bus.clear_i) begin
         state     <= IDLE;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         shreg     <= '0;
         beat      <= '0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         overflow  <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         count <= count + CW'(push) - CW'(pop);
         if (drop) begin
            overflow <= 1'b1;
         end

         case (state)
            IDLE: begin
               if (pop) begin
                  shreg     <= mem[rd_ptr];
                  beat      <= '0;
                  out_valid <= 1'b1;
                  out_last  <= (BEATS == 1);
                  state     <= SHIFT;
               end
            end
            SHIFT: begin
               if (hs) begin
                  if (out_last) begin
                     if (pop) begin
                        shreg    <= mem[rd_ptr];
                        beat     <= '0;
                        out_last <= (BEATS == 1);
                     end else begin
                        shreg     <= '0;
                        beat      <= '0;
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        state     <= IDLE;
                     end
                  end else begin
                     shreg    <= shreg << OUT_WIDTH;
                     beat     <= beat + 1'b1;
                     out_last <= (beat == PRE_LAST);
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.out_valid_o = out_valid;
   assign bus.out_data_o  = shreg[DATA_WIDTH-1 -: OUT_WIDTH];
   assign bus.out_last_o  = out_last;
   assign bus.overflow_o  = overflow;
   assign bus.count_o     = count;
   assign bus.empty_o     = (count == '0) && (state == IDLE);
endmodule

// File: tb/tb_result_serializer.sv
// Bench for result_serializer: directed scenarios plus a randomized stream checked against a queue of expected beats.
module tb_result_serializer;
   localparam int DW = 64;
   localparam int OW = 8;
   localparam int DP = 4;
   localparam int NB = DW / OW;
   localparam int CW = $clog2(DP + 1);

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   tests = 0;
   int   fails = 0;

   result_serializer_if #(.DATA_WIDTH(DW), .OUT_WIDTH(OW), .DEPTH(DP)) bus ();

   result_serializer #(.DATA_WIDTH(DW), .OUT_WIDTH(OW), .DEPTH(DP)) dut (
      .clk_i       (clk),
      .rst_async_i (rst),
      .bus         (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Beat i of a word, counting from the most significant slice.
   function automatic logic [OW-1:0] beat_of(input logic [DW-1:0] w, input int i);
      logic [DW-1:0] t;
      t = w >> (OW * (NB - 1 - i));
      return t[OW-1:0];
   endfunction

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      bus.out_ready_i = 1'b0;
      for (int c = 0; c < 6; c++) begin
         bus.valid_i = 1'b1;
         bus.data_i  = {$urandom, $urandom};
         next_cycle();
      end
      bus.valid_i = 1'b0;
      next_cycle();
      tests++;
      if (bus.overflow_o !== 1'b1 || bus.count_o !== CW'(4))
         $display("FAIL reset_precond: overflow=%b count=%0d, required 1 and 4", bus.overflow_o, bus.count_o);
      #3 rst = 1'b1;
      #1;
      tests++;
      if (bus.out_valid_o !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b required 0", bus.out_valid_o); end
      tests++;
      if (bus.out_data_o !== '0) begin fails++; $display("FAIL reset_data: got %h required 00", bus.out_data_o); end
      tests++;
      if (bus.out_last_o !== 1'b0) begin fails++; $display("FAIL reset_last: got %b required 0", bus.out_last_o); end
      tests++;
      if (bus.overflow_o !== 1'b0) begin fails++; $display("FAIL reset_overflow: got %b required 0", bus.overflow_o); end
      tests++;
      if (bus.empty_o !== 1'b1) begin fails++; $display("FAIL reset_empty: got %b required 1", bus.empty_o); end
      tests++;
      if (bus.count_o !== CW'(0)) begin fails++; $display("FAIL reset_count: got %0d required 0", bus.count_o); end
      #2 rst = 1'b0;
      bus.out_ready_i = 1'b1;
      for (int c = 0; c < 4; c++) begin
         next_cycle();
         tests++;
         if (bus.out_valid_o !== 1'b0 || bus.empty_o !== 1'b1) begin
            fails++;
            $display("FAIL reset_discard: valid=%b empty=%b, required 0 and 1", bus.out_valid_o, bus.empty_o);
         end
      end
   endtask

   task automatic test_single_word();
      logic [DW-1:0] w = 64'h0123456789ABCDEF;
      logic          exp_v;
      bus.out_ready_i = 1'b1;
      bus.valid_i     = 1'b1;
      bus.data_i      = w;
      next_cycle();
      bus.valid_i = 1'b0;
      tests++;
      if (bus.empty_o !== 1'b0) begin fails++; $display("FAIL single_empty_c1: got %b required 0", bus.empty_o); end
      for (int c = 1; c <= 10; c++) begin
         exp_v = (c >= 2 && c <= 9);
         tests++;
         if (bus.out_valid_o !== exp_v) begin
            fails++;
            $display("FAIL single_valid c%0d: got %b required %b", c, bus.out_valid_o, exp_v);
         end
         if (exp_v) begin
            tests++;
            if (bus.out_data_o !== beat_of(w, c - 2) || bus.out_last_o !== (c == 9)) begin
               fails++;
               $display("FAIL single_beat c%0d: got %h/%b required %h/%b", c, bus.out_data_o, bus.out_last_o,
                        beat_of(w, c - 2), (c == 9));
            end
         end
         if (c == 10) begin
            tests++;
            if (bus.empty_o !== 1'b1) begin fails++; $display("FAIL single_empty_c10: got %b required 1", bus.empty_o); end
         end else begin
            next_cycle();
         end
      end
   endtask

   task automatic test_backpressure();
      logic [DW-1:0] w = 64'h0123456789ABCDEF;
      logic          prev_v = 1'b0;
      logic          prev_r = 1'b0;
      logic          prev_l = 1'b0;
      logic [OW-1:0] prev_d = '0;
      int            nhs = 0;
      bus.out_ready_i = 1'b0;
      bus.valid_i     = 1'b1;
      bus.data_i      = w;
      next_cycle();
      bus.valid_i = 1'b0;
      for (int c = 1; c < 60 && nhs < NB; c++) begin
         if (prev_v && !prev_r) begin
            tests++;
            if (bus.out_valid_o !== 1'b1 || bus.out_data_o !== prev_d || bus.out_last_o !== prev_l) begin
               fails++;
               $display("FAIL bp_hold c%0d: got %b/%h/%b required 1/%h/%b", c, bus.out_valid_o, bus.out_data_o,
                        bus.out_last_o, prev_d, prev_l);
            end
         end
         if (c == 2) begin
            tests++;
            if (bus.out_valid_o !== 1'b1) begin fails++; $display("FAIL bp_first_valid: got %b required 1", bus.out_valid_o); end
         end
         bus.out_ready_i = (c >= 2) && ((c - 2) % 3 == 0);
         if (bus.out_valid_o === 1'b1 && bus.out_ready_i === 1'b1) begin
            tests++;
            if (bus.out_data_o !== beat_of(w, nhs) || bus.out_last_o !== (nhs == NB - 1)) begin
               fails++;
               $display("FAIL bp_beat %0d: got %h/%b required %h/%b", nhs, bus.out_data_o, bus.out_last_o,
                        beat_of(w, nhs), (nhs == NB - 1));
            end
            nhs++;
         end
         prev_v = bus.out_valid_o;
         prev_r = bus.out_ready_i;
         prev_d = bus.out_data_o;
         prev_l = bus.out_last_o;
         next_cycle();
      end
      tests++;
      if (nhs != NB) begin fails++; $display("FAIL bp_handshakes: got %0d required %0d", nhs, NB); end
      tests++;
      if (bus.out_valid_o !== 1'b0 || bus.empty_o !== 1'b1) begin
         fails++;
         $display("FAIL bp_done: valid=%b empty=%b required 0/1", bus.out_valid_o, bus.empty_o);
      end
   endtask

   task automatic test_overflow();
      logic [DW-1:0] w [6];
      logic [OW-1:0] exp_b [5*NB];
      int            n = 0;
      for (int i = 0; i < 6; i++) w[i] = {$urandom, $urandom};
      for (int i = 0; i < 5; i++)
         for (int j = 0; j < NB; j++) exp_b[i*NB + j] = beat_of(w[i], j);
      bus.out_ready_i = 1'b0;
      for (int c = 0; c < 6; c++) begin
         bus.valid_i = 1'b1;
         bus.data_i  = w[c];
         next_cycle();
      end
      bus.valid_i = 1'b0;
      tests++;
      if (bus.count_o !== CW'(4)) begin fails++; $display("FAIL ovf_count: got %0d required 4", bus.count_o); end
      tests++;
      if (bus.overflow_o !== 1'b1) begin fails++; $display("FAIL ovf_flag: got %b required 1", bus.overflow_o); end
      tests++;
      if (bus.out_valid_o !== 1'b1 || bus.out_data_o !== exp_b[0]) begin
         fails++;
         $display("FAIL ovf_head: got %b/%h required 1/%h", bus.out_valid_o, bus.out_data_o, exp_b[0]);
      end
      bus.out_ready_i = 1'b1;
      for (int c = 0; c < 50; c++) begin
         if (bus.out_valid_o === 1'b1) begin
            if (n < 5*NB) begin
               tests++;
               if (bus.out_data_o !== exp_b[n] || bus.out_last_o !== (n % NB == NB - 1)) begin
                  fails++;
                  $display("FAIL ovf_beat %0d: got %h/%b required %h/%b", n, bus.out_data_o, bus.out_last_o,
                           exp_b[n], (n % NB == NB - 1));
               end
            end
            n++;
         end
         next_cycle();
      end
      tests++;
      if (n != 5*NB) begin fails++; $display("FAIL ovf_beat_total: got %0d required %0d", n, 5*NB); end
      tests++;
      if (bus.overflow_o !== 1'b1 || bus.empty_o !== 1'b1) begin
         fails++;
         $display("FAIL ovf_sticky: overflow=%b empty=%b required 1/1", bus.overflow_o, bus.empty_o);
      end
   endtask

   task automatic test_back_to_back();
      logic [DW-1:0] w [2];
      logic          exp_v;
      int            idx;
      w[0] = {$urandom, $urandom};
      w[1] = {$urandom, $urandom};
      bus.out_ready_i = 1'b1;
      bus.valid_i     = 1'b1;
      bus.data_i      = w[0];
      next_cycle();
      bus.data_i = w[1];
      for (int c = 1; c <= 18; c++) begin
         if (c == 2) bus.valid_i = 1'b0;
         exp_v = (c >= 2 && c <= 17);
         tests++;
         if (bus.out_valid_o !== exp_v) begin
            fails++;
            $display("FAIL b2b_valid c%0d: got %b required %b", c, bus.out_valid_o, exp_v);
         end
         if (exp_v) begin
            idx = c - 2;
            tests++;
            if (bus.out_data_o !== beat_of(w[idx / NB], idx % NB) || bus.out_last_o !== (c == 9 || c == 17)) begin
               fails++;
               $display("FAIL b2b_beat c%0d: got %h/%b required %h/%b", c, bus.out_data_o, bus.out_last_o,
                        beat_of(w[idx / NB], idx % NB), (c == 9 || c == 17));
            end
         end
         if (c < 18) next_cycle();
      end
   endtask

   task automatic test_clear();
      logic [DW-1:0] w0 = {$urandom, $urandom};
      bus.out_ready_i = 1'b1;
      bus.valid_i     = 1'b1;
      bus.data_i      = w0;
      next_cycle();
      bus.data_i = {$urandom, $urandom};
      next_cycle();
      bus.valid_i = 1'b0;
      for (int c = 2; c < 5; c++) next_cycle();
      tests++;
      if (bus.out_valid_o !== 1'b1 || bus.out_data_o !== beat_of(w0, 3) || bus.count_o !== CW'(1)) begin
         fails++;
         $display("FAIL clr_precond: got %b/%h/count %0d required 1/%h/1", bus.out_valid_o, bus.out_data_o,
                  bus.count_o, beat_of(w0, 3));
      end
      bus.clear_i = 1'b1;
      bus.valid_i = 1'b1;
      bus.data_i  = {$urandom, $urandom};
      next_cycle();
      bus.clear_i = 1'b0;
      bus.valid_i = 1'b0;
      tests++;
      if (bus.out_valid_o !== 1'b0 || bus.count_o !== CW'(0) || bus.overflow_o !== 1'b0 || bus.empty_o !== 1'b1) begin
         fails++;
         $display("FAIL clr_state: valid=%b count=%0d overflow=%b empty=%b required 0/0/0/1", bus.out_valid_o,
                  bus.count_o, bus.overflow_o, bus.empty_o);
      end
      for (int c = 0; c < 12; c++) begin
         next_cycle();
         tests++;
         if (bus.out_valid_o !== 1'b0) begin fails++; $display("FAIL clr_no_beats c%0d: got %b required 0", c, bus.out_valid_o); end
      end
      bus.out_ready_i = 1'b0;
      for (int c = 0; c < 6; c++) begin
         bus.valid_i = 1'b1;
         bus.data_i  = {$urandom, $urandom};
         next_cycle();
      end
      bus.valid_i = 1'b0;
      bus.clear_i = 1'b1;
      next_cycle();
      bus.clear_i = 1'b0;
      tests++;
      if (bus.overflow_o !== 1'b0 || bus.count_o !== CW'(0) || bus.empty_o !== 1'b1) begin
         fails++;
         $display("FAIL clr_overflow: overflow=%b count=%0d empty=%b required 0/0/1", bus.overflow_o, bus.count_o,
                  bus.empty_o);
      end
   endtask

   task automatic test_random_stream();
      logic [OW:0]   exp_q [$];
      logic [OW:0]   e;
      logic [DW-1:0] w;
      logic          prev_v = 1'b0;
      logic          prev_r = 1'b0;
      logic          prev_l = 1'b0;
      logic [OW-1:0] prev_d = '0;
      int            sent = 0;
      int            done = 0;
      for (int cyc = 0; cyc < 4000 && (sent < 40 || exp_q.size() != 0); cyc++) begin
         if (prev_v && !prev_r) begin
            tests++;
            if (bus.out_valid_o !== 1'b1 || bus.out_data_o !== prev_d || bus.out_last_o !== prev_l) begin
               fails++;
               $display("FAIL rnd_hold cyc%0d: got %b/%h/%b required 1/%h/%b", cyc, bus.out_valid_o,
                        bus.out_data_o, bus.out_last_o, prev_d, prev_l);
            end
         end
         bus.out_ready_i = ($urandom_range(0, 9) < 6);
         if (sent < 40 && (sent - done) < DP && $urandom_range(0, 1) == 1) begin
            w = {$urandom, $urandom};
            bus.valid_i = 1'b1;
            bus.data_i  = w;
            for (int j = 0; j < NB; j++) exp_q.push_back({(j == NB - 1), beat_of(w, j)});
            sent++;
         end else begin
            bus.valid_i = 1'b0;
         end
         if (bus.out_valid_o === 1'b1 && bus.out_ready_i === 1'b1) begin
            tests++;
            if (exp_q.size() == 0) begin
               fails++;
               $display("FAIL rnd_extra_beat cyc%0d: got %h required none", cyc, bus.out_data_o);
            end else begin
               e = exp_q.pop_front();
               if (bus.out_data_o !== e[OW-1:0] || bus.out_last_o !== e[OW]) begin
                  fails++;
                  $display("FAIL rnd_beat cyc%0d: got %h/%b required %h/%b", cyc, bus.out_data_o, bus.out_last_o,
                           e[OW-1:0], e[OW]);
               end
               if (e[OW]) done++;
            end
         end
         prev_v = bus.out_valid_o;
         prev_r = bus.out_ready_i;
         prev_d = bus.out_data_o;
         prev_l = bus.out_last_o;
         next_cycle();
      end
      bus.valid_i = 1'b0;
      tests++;
      if (exp_q.size() != 0 || sent != 40) begin
         fails++;
         $display("FAIL rnd_complete: %0d beats outstanding, %0d words sent, required 0 and 40", exp_q.size(), sent);
      end
      next_cycle();
      tests++;
      if (bus.empty_o !== 1'b1 || bus.overflow_o !== 1'b0) begin
         fails++;
         $display("FAIL rnd_final: empty=%b overflow=%b required 1/0", bus.empty_o, bus.overflow_o);
      end
   endtask

   initial begin
      bus.valid_i     = 1'b0;
      bus.data_i      = '0;
      bus.clear_i     = 1'b0;
      bus.out_ready_i = 1'b0;
      #23 rst = 1'b0;
      next_cycle();
      test_reset();
      test_single_word();
      test_backpressure();
      test_overflow();
      bus.clear_i = 1'b1;
      next_cycle();
      bus.clear_i = 1'b0;
      test_back_to_back();
      next_cycle();
      test_clear();
      test_random_stream();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/result_serializer.md
RESULT_SERIALIZER -- requirements
Module: result_serializer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, giving the width of a captured result word (external result bus width).
REQ-002 SHALL have parameter OUT_WIDTH, default 8, giving the serial beat width; DATA_WIDTH SHALL be an integer multiple of OUT_WIDTH.
REQ-003 SHALL have parameter DEPTH, default 4, giving the word FIFO depth (power of two, >=2).
REQ-004 SHALL have one clock and an asynchronous, active-high reset:
- clk_i  input  1  clock; all state on rising edge.
- rst_async_i  input  1  asynchronous reset, active high.
REQ-005 SHALL have the following data and control ports:
- valid_i  input  1  result word valid; one word per cycle.
- data_i  input  DATA_WIDTH  result word.
- clear_i  input  1  synchronous flush of the FIFO, shifter and overflow flag.
- out_ready_i  input  1  downstream accepts the current beat.
- out_valid_o  output  1  beat valid.
- out_data_o  output  OUT_WIDTH  beat data.
- out_last_o  output  1  final beat of a word.
- overflow_o  output  1  sticky word-dropped flag.
- empty_o  output  1  FIFO empty and shifter idle.
- count_o  output  $clog2(DEPTH+1)  FIFO occupancy; excludes the shifter.

Function
REQ-006 SHALL hold words in a DEPTH-entry FIFO; a push occurs when valid_i=1 and the FIFO is not full, or when it is full and a pop occurs in the same cycle.
REQ-007 SHALL drop valid_i while the FIFO is full with no same-cycle pop, and SHALL set overflow_o=1 on the next edge; overflow_o stays 1 until clear_i or reset.
REQ-008 SHALL implement FSM states IDLE and SHIFT.
REQ-009 SHALL behave as follows in IDLE:
- out_valid_o=0.
- If the FIFO is non-empty, pop the head word into the shift register, clear the beat counter, and go to SHIFT.
REQ-010 SHALL behave as follows in SHIFT:
- out_valid_o=1.
- out_data_o = the most significant OUT_WIDTH bits of the shift register (MSB beat first).
- out_last_o=1 only when the beat counter = DATA_WIDTH/OUT_WIDTH-1.
REQ-011 SHALL, on each handshake (out_valid_o and out_ready_i), shift the register left by OUT_WIDTH and increment the beat counter.
REQ-012 SHALL handle the handshake of the last beat as follows:
- If the FIFO is non-empty, pop the next word and stay in SHIFT, giving back-to-back words with no idle cycle.
- Otherwise, go to IDLE.
REQ-013 SHALL hold out_data_o, out_last_o and out_valid_o stable while out_valid_o=1 and out_ready_i=0.
REQ-014 SHALL present the first beat two cycles after valid_i when the block is idle and empty: push at edge N, pop at edge N+1, out_valid_o=1 from cycle N+2.
REQ-015 SHALL give clear_i priority over valid_i and over a handshake; on the next edge count_o=0, overflow_o=0, state=IDLE and out_valid_o=0; a word presented with clear_i is discarded.
REQ-016 SHALL drive empty_o=1 exactly when count_o=0 and state=IDLE.
REQ-017 SHALL wrap the FIFO read/write pointers modulo DEPTH; count_o SHALL range 0..DEPTH with no wrap.

Reset
REQ-018 SHALL, while rst_async_i=1, immediately force:
- state=IDLE, pointers and count_o=0.
- out_valid_o=0, out_last_o=0, out_data_o=0.
- overflow_o=0, empty_o=1.
REQ-019 SHALL discard any in-progress word and all FIFO contents on reset mid-transfer.
REQ-020 SHALL resume normal operation on the first rising clk_i edge after rst_async_i deasserts.

Verification (DATA_WIDTH=64, OUT_WIDTH=8, DEPTH=4)
REQ-021 SHALL cover reset: assert rst_async_i mid-cycle -> outputs zero at once, empty_o=1, no clock edge needed.
REQ-022 SHALL cover single word: data_i=0x0123456789ABCDEF at cycle 0, out_ready_i=1 -> out_valid_o from cycle 2, beats 01,23,45,67,89,AB,CD,EF on cycles 2-9, out_last_o only with EF, empty_o=1 at cycle 10.
REQ-023 SHALL cover backpressure: out_ready_i toggles 1,0,0,1,... -> beat held unchanged through stalls, sequence identical to REQ-022, 8 handshakes total.
REQ-024 SHALL cover overflow: six consecutive valid_i with out_ready_i=0 -> word 1 in shifter, words 2-5 in FIFO, count_o=4, word 6 dropped, overflow_o=1; releasing ready yields exactly 40 beats (words 1-5).
REQ-025 SHALL cover back-to-back: two words at cycles 0-1, out_ready_i=1 -> 16 contiguous beats on cycles 2-17, out_last_o on cycles 9 and 17, no gap.
REQ-026 SHALL cover clear mid-transfer: clear_i at beat 3 with one word queued -> next cycle out_valid_o=0, count_o=0, overflow_o=0, no further beats.
